// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Bundles the raster-timing outputs of vga_timing_gen. The
//             generator drives them through the master modport, and a
//             renderer or display sink reads them through the slave modport.
//  Signals  : x[9:0], y[9:0]  current horizontal / vertical count
//             en              visible-area flag
//             pix_tick        one-clk pulse per pixel advance
//             frame_start     one-clk pulse on wrap to (0,0)
//             hsync, vsync    active-low syncs (pipelined)
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       en;
  logic       pix_tick;
  logic       frame_start;
  logic       hsync;
  logic       vsync;

  modport master (
    output x, y, en, pix_tick, frame_start, hsync, vsync
  );

  modport slave (
    input  x, y, en, pix_tick, frame_start, hsync, vsync
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing generator. The clock is divided down to a
//             pixel tick, which drives a horizontal/vertical counter pair.
//             Sync pulses, the visible-area flag and a frame-start strobe are
//             decoded from the counters.
//  Ports    : clk          system clock
//             reset        asynchronous active-high reset
//             vga (master) x, y, en, pix_tick, frame_start, hsync, vsync
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_stop  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_stop  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0] c_div_last = 3'(CLK_DIV - 1);

  logic [2:0] r_div_cnt;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_tick;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_hsync_raw;
  logic       w_vsync_raw;

  // With CLK_DIV=1 the divider sits at 0 == c_div_last, so the tick is
  // permanently high, including while reset is asserted.
  assign w_tick   = (r_div_cnt == c_div_last);
  assign w_h_last = (r_h_cnt == c_h_last);
  assign w_v_last = (r_v_cnt == c_v_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      if (w_tick) r_div_cnt <= '0;
      else        r_div_cnt <= r_div_cnt + 3'd1;

      if (w_tick) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          if (w_v_last) r_v_cnt <= '0;
          else          r_v_cnt <= r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  assign w_hsync_raw = ~((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_stop));
  assign w_vsync_raw = ~((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_stop));

  assign vga.x           = r_h_cnt;
  assign vga.y           = r_v_cnt;
  assign vga.en          = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
  assign vga.pix_tick    = w_tick;
  // Combinational, so an asynchronous reset mid-frame clears it at once.
  assign vga.frame_start = w_tick & w_h_last & w_v_last;

  // Syncs are delayed to line up with the renderer's memory read latency.
  // The delay stages reset to the inactive (high) level.
  if (PIPE_DLY == 0) begin : g_sync_direct
    assign vga.hsync = w_hsync_raw;
    assign vga.vsync = w_vsync_raw;
  end else begin : g_sync_pipe
    logic [PIPE_DLY-1:0] r_hs_pipe;
    logic [PIPE_DLY-1:0] r_vs_pipe;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_hs_pipe <= '1;
        r_vs_pipe <= '1;
      end else begin
        r_hs_pipe[0] <= w_hsync_raw;
        r_vs_pipe[0] <= w_vsync_raw;
        for (int i = 1; i < PIPE_DLY; i++) begin
          r_hs_pipe[i] <= r_hs_pipe[i-1];
          r_vs_pipe[i] <= r_vs_pipe[i-1];
        end
      end
    end

    assign vga.hsync = r_hs_pipe[PIPE_DLY-1];
    assign vga.vsync = r_vs_pipe[PIPE_DLY-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Three instances run in
//             parallel on one clock and one reset:
//               dut0 - default timing (CLK_DIV=4, PIPE_DLY=1)
//               dut1 - default horizontal timing, short frame,
//                      CLK_DIV=1, PIPE_DLY=3
//               dut2 - tiny raster, CLK_DIV=3, PIPE_DLY=0
//             Each instance's outputs are compared every cycle against a
//             closed-form model. The model works from the number of clk
//             edges since reset release. Randomly placed asynchronous
//             resets are inserted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // dut1: short frame with 8 lines, 6400 clk per frame
  localparam int V1A = 4, V1F = 1, V1S = 2, V1B = 1;
  // dut2: 17 x 10 raster, 510 clk per frame
  localparam int H2A = 10, H2F = 2, H2S = 3, H2B = 2;
  localparam int V2A = 6,  V2F = 1, V2S = 2, V2B = 1;
  localparam int PH1 = 7000;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       pt;
    logic       fs;
    logic       hs;
    logic       vs;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  longint e = 0;            // clk edges since reset release
  int     n_checks = 0;
  int     n_errors = 0;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();

  vga_timing_gen dut0 (.clk(clk), .reset(reset), .vga(vif0));

  vga_timing_gen #(
    .V_ACTIVE(V1A), .V_FP(V1F), .V_SYNC(V1S), .V_BP(V1B),
    .CLK_DIV(1), .PIPE_DLY(3)
  ) dut1 (.clk(clk), .reset(reset), .vga(vif1));

  vga_timing_gen #(
    .H_ACTIVE(H2A), .H_FP(H2F), .H_SYNC(H2S), .H_BP(H2B),
    .V_ACTIVE(V2A), .V_FP(V2F), .V_SYNC(V2S), .V_BP(V2B),
    .CLK_DIV(3), .PIPE_DLY(0)
  ) dut2 (.clk(clk), .reset(reset), .vga(vif2));

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) e <= 0;
    else       e <= e + 1;
  end

  // Reference: after e edges, floor(e/d) pixel ticks have happened. The
  // syncs show the raw decode from p edges earlier, or idle-high before that.
  function automatic exp_t model(longint ec, int d, int p,
                                 int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    exp_t   r;
    longint ht = ha + hf + hsw + hb;
    longint vt = va + vf + vsw + vb;
    longint t  = ec / d;
    longint h  = t % ht;
    longint v  = (t / ht) % vt;
    longint t2, h2, v2;
    r.x  = 10'(h);
    r.y  = 10'(v);
    r.en = (h < ha) && (v < va);
    r.pt = ((ec % d) == longint'(d - 1));
    r.fs = r.pt && (h == ht - 1) && (v == vt - 1);
    if (ec < p) begin
      r.hs = 1'b1;
      r.vs = 1'b1;
    end else begin
      t2   = (ec - p) / d;
      h2   = t2 % ht;
      v2   = (t2 / ht) % vt;
      r.hs = !((h2 >= ha + hf) && (h2 < ha + hf + hsw));
      r.vs = !((v2 >= va + vf) && (v2 < va + vf + vsw));
    end
    return r;
  endfunction

  task automatic check_dut(input string tag, input exp_t obs, input exp_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s e=%0d observed x=%0d y=%0d en=%b tick=%b fs=%b hs=%b vs=%b expected x=%0d y=%0d en=%b tick=%b fs=%b hs=%b vs=%b",
             tag, e, obs.x, obs.y, obs.en, obs.pt, obs.fs, obs.hs, obs.vs,
             exp.x, exp.y, exp.en, exp.pt, exp.fs, exp.hs, exp.vs);
    end
  endtask

  task automatic check_int(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs == exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check_dut("dut0", {vif0.x, vif0.y, vif0.en, vif0.pix_tick, vif0.frame_start, vif0.hsync, vif0.vsync},
              model(e, 4, 1, 640, 16, 96, 48, 480, 10, 2, 33));
    check_dut("dut1", {vif1.x, vif1.y, vif1.en, vif1.pix_tick, vif1.frame_start, vif1.hsync, vif1.vsync},
              model(e, 1, 3, 640, 16, 96, 48, V1A, V1F, V1S, V1B));
    check_dut("dut2", {vif2.x, vif2.y, vif2.en, vif2.pix_tick, vif2.frame_start, vif2.hsync, vif2.vsync},
              model(e, 3, 0, H2A, H2F, H2S, H2B, V2A, V2F, V2S, V2B));
  endtask

  // Event timestamps (in edges since release) gathered in the first run
  longint d0_tick1 = -1, d0_x656 = -1, d0_hfall = -1, d0_hrise = -1, d0_y1 = -1;
  longint d1_x656 = -1, d1_hfall = -1, d1_hrise = -1, d1_y1 = -1;
  int     d1_vs_low = 0, d1_ticks = 0, d2_fs = 0, d2_en = 0;

  task automatic collect();
    if (d0_tick1 < 0 && vif0.pix_tick === 1'b1) d0_tick1 = e;
    if (d0_x656 < 0 && vif0.x == 10'd656) d0_x656 = e;
    if (d0_hfall < 0 && vif0.hsync === 1'b0) d0_hfall = e;
    else if (d0_hfall >= 0 && d0_hrise < 0 && vif0.hsync === 1'b1) d0_hrise = e;
    if (d0_y1 < 0 && vif0.y == 10'd1) d0_y1 = e;
    if (d1_x656 < 0 && vif1.x == 10'd656) d1_x656 = e;
    if (d1_hfall < 0 && vif1.hsync === 1'b0) d1_hfall = e;
    else if (d1_hfall >= 0 && d1_hrise < 0 && vif1.hsync === 1'b1) d1_hrise = e;
    if (d1_y1 < 0 && vif1.y == 10'd1) d1_y1 = e;
    if (e <= 6400 && vif1.vsync === 1'b0) d1_vs_low++;
    if (e <= 6400 && vif1.pix_tick === 1'b1) d1_ticks++;
    if (vif2.frame_start === 1'b1) d2_fs++;
    if (e <= 510 && vif2.en === 1'b1 && vif2.pix_tick === 1'b1) d2_en++;
  endtask

  task automatic run(input int n, input bit stats);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_all();
      if (stats) collect();
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    #1 reset = 1'b0;

    run(PH1, 1'b1);
    check_int("d0_first_tick",    d0_tick1, 3);
    check_int("d0_hsync_delay",   d0_hfall - d0_x656, 1);
    check_int("d0_hsync_width",   d0_hrise - d0_hfall, 384);
    check_int("d0_line_period",   d0_y1, 3200);
    check_int("d1_hsync_delay",   d1_hfall - d1_x656, 3);
    check_int("d1_hsync_width",   d1_hrise - d1_hfall, 96);
    check_int("d1_line_period",   d1_y1, 800);
    check_int("d1_vsync_low_clk", d1_vs_low, 2 * 800);
    check_int("d1_tick_count",    d1_ticks, 6400);
    check_int("d2_frame_pulses",  d2_fs, (PH1 + 1) / 510);
    check_int("d2_en_ticks",      d2_en, H2A * V2A);

    // Asynchronous resets dropped at random points in the raster
    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(100, 4000)), 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_all();
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        check_all();
      end
      #1 reset = 1'b0;
    end

    run(8000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- CLK_DIV, 4, clk cycles per pixel (range 1..8)
- PIPE_DLY, 1, clk-cycle delay applied to hsync/vsync so they align with renderer memory latency (range 0..3)

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning. The clock is single; reset is asynchronous and active-high.
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- x, output, 10, current horizontal count (0..H_TOTAL-1)
- y, output, 10, current vertical count (0..V_TOTAL-1)
- en, output, 1, high while x<H_ACTIVE and y<V_ACTIVE
- pix_tick, output, 1, one-clk pulse marking each pixel advance
- frame_start, output, 1, one-clk pulse when counters wrap to (0,0)
- hsync, output, 1, horizontal sync, active-low, delayed PIPE_DLY clk
- vsync, output, 1, vertical sync, active-low, delayed PIPE_DLY clk

Function
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-004 The divider counter div_cnt SHALL count 0..CLK_DIV-1 and then wrap; pix_tick SHALL be high for exactly the clk cycle in which div_cnt==CLK_DIV-1.
REQ-005 When CLK_DIV=1, pix_tick SHALL be constantly high after reset.
REQ-006 On each pix_tick, h_cnt SHALL increment; at h_cnt==H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment in the same cycle.
REQ-007 When h_cnt wraps and v_cnt==V_TOTAL-1, v_cnt SHALL wrap to 0 in the same cycle.
REQ-008 h_cnt and v_cnt SHALL hold their values on all non-tick cycles.
REQ-009 x SHALL equal h_cnt and y SHALL equal v_cnt, both driven directly from registers with no added logic.
REQ-010 en SHALL be a combinational decode of the registered counters with zero latency relative to x and y.
REQ-011 The raw hsync SHALL be low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-012 The raw vsync SHALL be low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491).
REQ-013 The hsync and vsync outputs SHALL be the raw values passed through a PIPE_DLY-stage clk shift register; PIPE_DLY=0 SHALL mean direct combinational output.
REQ-014 frame_start SHALL be high for exactly the single clk cycle in which pix_tick is high with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
REQ-015 No output SHALL exhibit an X state or glitch between registered transitions, apart from the combinational decodes named above.

Reset
REQ-016 While reset is high, div_cnt, h_cnt and v_cnt SHALL be 0 and every sync delay stage SHALL be 1, asynchronously and independent of clk.
REQ-017 During reset, the outputs SHALL be x=0, y=0, en=1, pix_tick=0 (or 1 when CLK_DIV=1), frame_start=0, hsync=1 and vsync=1.
REQ-018 On reset deassertion the first pix_tick SHALL occur on the CLK_DIV-th clk edge, and counting SHALL restart from (0,0) with no partial-frame catch-up.
REQ-019 A reset asserted mid-frame SHALL take effect immediately and SHALL NOT generate a frame_start pulse.

Verification
REQ-020 Reset release, defaults -> x=0, y=0, en=1, hsync=vsync=1; pix_tick first high in clk cycle 4 and every 4 clk thereafter.
REQ-021 Line wrap -> after 800 ticks (3200 clk), x returns to 0 and y=1; en is low for x=640..799.
REQ-022 Hsync timing -> hsync is low for exactly 96 ticks (384 clk), starting 1 clk after x becomes 656 (PIPE_DLY=1); with PIPE_DLY=0 it starts in the same cycle.
REQ-023 Full frame -> 420000 ticks (1,680,000 clk) per frame; frame_start pulses exactly once per frame; vsync is low for 1600 ticks while y=490..491; en-high tick count is 307200.
REQ-024 Mid-frame reset at x=300, y=200 -> x, y and div_cnt immediately go to 0, hsync=vsync=1 within the reset cycle, and no frame_start pulse occurs.
REQ-025 CLK_DIV=1, PIPE_DLY=3 -> pix_tick is high every cycle, line period is 800 clk, and hsync falls 3 clk after x becomes 656.
